// File: rtl/screen_scan_pkg.sv
// Shared CHIP-8 display constants and scan-FSM state encoding.
// SCREEN_SCAN_DOUBLE_EN selects the 2x output scale used by the scanner.
package screen_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } scan_state_t;

  localparam logic [15:0] SCREEN_START  = 16'h0100;
  localparam int unsigned SCREEN_W      = 64;
  localparam int unsigned SCREEN_H      = 32;
  localparam int unsigned BYTES_PER_ROW = SCREEN_W / 8;

`ifdef SCREEN_SCAN_DOUBLE_EN
  localparam int unsigned SCALE = 2;
`else
  localparam int unsigned SCALE = 1;
`endif

endpackage

// File: rtl/screen_scan_shifter.sv
// scan_shifter: holds one framebuffer byte and emits it MSB-first on a
// valid/ready stream. With SCREEN_SCAN_DOUBLE_EN each bit is presented twice.
module scan_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       ready,
  output logic       pix_valid,
  output logic       pix_data,
  output logic [3:0] col,
  output logic       last_bit,
  output logic       byte_done
);

  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       valid_q;
  logic       hs;
  logic       advance;

  assign hs        = valid_q && ready;
  assign pix_valid = valid_q;
  assign pix_data  = shreg[7];
  assign byte_done = hs && last_bit;

`ifdef SCREEN_SCAN_DOUBLE_EN
  logic rep;

  // Shift only after the second copy of a bit has been accepted.
  assign advance  = hs && rep;
  assign last_bit = (bit_cnt == 3'd7) && rep;
  assign col      = {bit_cnt, rep};

  // Repeat toggle: first/second copy of the current bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rep <= 1'b0;
    else if (load) rep <= 1'b0;
    else if (hs)   rep <= ~rep;
  end
`else
  assign advance  = hs;
  assign last_bit = (bit_cnt == 3'd7);
  assign col      = {1'b0, bit_cnt};
`endif

  // Byte load, shift-on-handshake and valid hold until the byte is drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= '0;
      valid_q <= 1'b1;
    end else begin
      if (advance) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/screen_scan.sv
// screen_scan: reads the CHIP-8 framebuffer through the arbitrated memory port
// and streams it pixel by pixel to the display driver.
// Optional macro SCREEN_SCAN_DOUBLE_EN: 2x pixel doubling (128 x 64 output).
module screen_scan
  import screen_scan_pkg::*;
#(
  parameter logic [15:0] screen_start  = SCREEN_START,
  parameter int unsigned rows          = SCREEN_H,
  parameter int unsigned bytes_per_row = BYTES_PER_ROW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  input  logic        mem_grant,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_read_byte,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        pix_last
);

  localparam int unsigned RW = $clog2(rows);
  localparam int unsigned BW = $clog2(bytes_per_row);

  scan_state_t   state, next_state;
  logic [RW-1:0] row;
  logic [BW-1:0] byte_idx;
  logic          row_rep;
  logic [3:0]    col;
  logic          last_bit, byte_done;
  logic          last_byte, last_row, row_pass_done, frame_end;

  assign last_byte = (byte_idx == BW'(bytes_per_row - 1));
  assign last_row  = (row == RW'(rows - 1));
  assign frame_end = last_byte && last_row && row_pass_done;

  assign busy     = (state != IDLE);
  assign mem_read = (state == FETCH) && mem_grant;
  assign pix_last = pix_valid && last_bit && frame_end;
  assign pix_x    = 7'(byte_idx) * 7'(8 * SCALE) + 7'(col);
  assign pix_y    = 6'(row) * 6'(SCALE) + 6'(row_rep);

  scan_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (state == WAIT),
    .din       (mem_read_byte),
    .ready     (pix_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .col       (col),
    .last_bit  (last_bit),
    .byte_done (byte_done)
  );

`ifdef SCREEN_SCAN_DOUBLE_EN
  assign row_pass_done = row_rep;

  // Each framebuffer row is scanned twice; this marks the second pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        row_rep <= 1'b0;
    else if (state == IDLE && start)                  row_rep <= 1'b0;
    else if (state == EMIT && byte_done && last_byte) row_rep <= ~row_rep;
  end
`else
  assign row_rep       = 1'b0;
  assign row_pass_done = 1'b1;
`endif

  // Scan state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: fetch a byte, wait for its data, drain it, repeat.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)     next_state = FETCH;
      FETCH:   if (mem_grant) next_state = WAIT;
      WAIT:                   next_state = EMIT;
      EMIT:    if (byte_done) next_state = frame_end ? IDLE : FETCH;
      default:                next_state = IDLE;
    endcase
  end

  // Address and row/byte sequencing; a first row pass rewinds to the row start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      row      <= '0;
      byte_idx <= '0;
    end else if (state == IDLE && start) begin
      mem_addr <= screen_start;
      row      <= '0;
      byte_idx <= '0;
    end else if (state == EMIT && byte_done && !frame_end) begin
      if (!last_byte) begin
        mem_addr <= mem_addr + 16'd1;
        byte_idx <= byte_idx + BW'(1);
      end else if (!row_pass_done) begin
        mem_addr <= mem_addr - 16'(bytes_per_row - 1);
        byte_idx <= '0;
      end else begin
        mem_addr <= mem_addr + 16'd1;
        byte_idx <= '0;
        row      <= row + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_screen_scan.sv
// Self-checking bench for screen_scan: framebuffer memory model, pixel and
// read-address scoreboards, table-driven frames plus latency/reset sequences.
module tb_screen_scan;

  logic        clk = 1'b0;
  logic        reset, start, busy;
  logic        mem_grant, mem_read;
  logic [15:0] mem_addr;
  logic [7:0]  mem_read_byte;
  logic        pix_valid, pix_ready, pix_data, pix_last;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;

  always #5 clk = ~clk;

  screen_scan dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .mem_grant     (mem_grant),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_read_byte (mem_read_byte),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_last      (pix_last)
  );

`ifdef SCREEN_SCAN_DOUBLE_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int NPIX   = 2048 * SC * SC;
  localparam int NREADS = 256 * SC;

  // Framebuffer memory: data appears the cycle after the read strobe.
  logic [7:0] fb [256];
  always @(posedge clk) if (mem_read) mem_read_byte <= fb[8'(mem_addr - 16'h0100)];

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
    logic       d;
    logic       last;
  } pix_t;

  pix_t        exp_q[$];
  logic [15:0] addr_q[$];
  int n_cmp = 0, n_err = 0;
  int n_pix, n_rd, n_lit;
  bit mon_en = 0;
  bit prev_stall;
  pix_t prev_p, e;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall)
        chk("stall_hold", {pix_valid, pix_data, pix_x, pix_y},
            {1'b1, prev_p.d, prev_p.x, prev_p.y});
      chk("last_gated", int'(pix_last & ~pix_valid), 0);
      if (mem_read) begin
        n_rd++;
        chk("read_grant", int'(mem_grant), 1);
        if (addr_q.size() == 0) chk("read_extra", 1, 0);
        else chk("read_addr", mem_addr, addr_q.pop_front());
      end
      if (pix_valid && pix_ready) begin
        n_pix++;
        if (pix_data) n_lit++;
        if (exp_q.size() == 0) chk("pix_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pixel", {pix_x, pix_y, pix_data, pix_last}, e);
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_p     = '{x: pix_x, y: pix_y, d: pix_data, last: pix_last};
    end
  end

  task automatic build_expect();
    logic [7:0] bv;
    int cx, cy;
    exp_q.delete();
    addr_q.delete();
    for (int y = 0; y < 32 * SC; y++)
      for (int x = 0; x < 64 * SC; x++) begin
        cx = x / SC;
        cy = y / SC;
        bv = fb[cy * 8 + cx / 8];
        exp_q.push_back('{x: 7'(x), y: 6'(y), d: bv[7 - (cx % 8)],
                          last: (x == 64 * SC - 1) && (y == 32 * SC - 1)});
      end
    for (int r = 0; r < 32; r++)
      for (int p = 0; p < SC; p++)
        for (int b = 0; b < 8; b++) addr_q.push_back(16'h0100 + 16'(r * 8 + b));
  endtask

  task automatic run_frame(input bit rdy_rand, input logic [15:0] gap_addr);
    int gap = 0;
    int budget = NPIX * 4 + 5000;
    build_expect();
    n_pix = 0; n_rd = 0; n_lit = 0; prev_stall = 0;
    mon_en = 1;
    @(posedge clk); #1 start = 1; mem_grant = 1; pix_ready = 1;
    @(posedge clk); #1 start = 0;
    while (busy && budget > 0) begin
      pix_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (gap_addr != 0 && mem_addr == gap_addr && !pix_valid && gap < 5) begin
        mem_grant = 0;
        gap++;
      end else mem_grant = 1;
      @(posedge clk); #1;
      budget--;
    end
    mon_en = 0;
    mem_grant = 1;
    pix_ready = 1;
    chk("frame_done_busy", int'(busy), 0);
    chk("pix_count", n_pix, NPIX);
    chk("read_count", n_rd, NREADS);
    chk("pix_left", exp_q.size(), 0);
    chk("addr_left", addr_q.size(), 0);
    if (gap_addr != 0) chk("grant_gap_applied", gap, 5);
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [7:0]  val;
    bit          rdy_rand;
    logic [15:0] gap;
    int          lit;
  } vec_t;

  vec_t vecs[5];

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_mem_read"}, int'(mem_read), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_data"}, int'(pix_data), 0);
    chk({tag, "_pix_last"}, int'(pix_last), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
  endtask

  initial begin
    int cnt, guard;
    vecs[0] = '{off: 8'h00, val: 8'hA5, rdy_rand: 0, gap: 16'h0000, lit: 4};
    vecs[1] = '{off: 8'hFF, val: 8'h01, rdy_rand: 0, gap: 16'h0000, lit: 1};
    vecs[2] = '{off: 8'h08, val: 8'h3C, rdy_rand: 0, gap: 16'h0108, lit: 4};
    vecs[3] = '{off: 8'h00, val: 8'hA5, rdy_rand: 1, gap: 16'h0000, lit: 4};
    vecs[4] = '{off: 8'h00, val: 8'h80, rdy_rand: 0, gap: 16'h0000, lit: 1};

    reset = 1; start = 0; mem_grant = 0; pix_ready = 0;
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 0;

    for (int unsigned v = 0; v < 5; v++) begin
      for (int i = 0; i < 256; i++) fb[i] = 8'h00;
      fb[vecs[v].off] = vecs[v].val;
      run_frame(vecs[v].rdy_rand, vecs[v].gap);
      chk("lit_count", n_lit, vecs[v].lit * SC * SC);
    end

    // Start latency, then reset in the middle of the frame.
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    fb[0] = 8'hA5;
    @(posedge clk); #1 start = 1; mem_grant = 1; pix_ready = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("lat_fetch_read", {mem_read, busy, pix_valid}, 3'b110);
    chk("lat_fetch_addr", mem_addr, 16'h0100);
    @(negedge clk);
    chk("lat_wait", {mem_read, pix_valid}, 2'b00);
    @(negedge clk);
    chk("lat_first_pix", {pix_valid, pix_data, pix_x, pix_y}, {2'b11, 13'd0});
    cnt = 0; guard = 0;
    while (cnt < 100 && guard < 1000) begin
      if (pix_valid && pix_ready) cnt++;
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_100", cnt, 100);
    #2 reset = 1;
    #1 check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    check_outputs_zero("midreset_hold");
    @(posedge clk); #1 reset = 0;
    run_frame(1'b0, 16'h0000);
    chk("restart_lit", n_lit, 4 * SC * SC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/screen_scan.md
Name: screen_scan

Overview:
Downstream consumer of the CHIP-8 framebuffer written by the sprite-drawing GPU. It reads the 64 x 32 monochrome framebuffer (256 bytes, 8 bytes per row) over the shared memory interface and emits one pixel at a time on a valid/ready stream toward the display driver. It takes memory cycles only when granted by the arbiter, so it never collides with GPU or CPU accesses.

Parameters:
screen_start, 'h100, byte address of framebuffer row 0 / byte 0
rows, 32, framebuffer rows
bytes_per_row, 8, bytes per row (64 pixels)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin scanning one frame
busy  out  1  high from start acceptance until last pixel handshakes
mem_grant  in  1  arbiter permits a read this cycle
mem_read  out  1  read strobe; high only when state==FETCH and mem_grant
mem_addr  out  16  read address; held stable while in FETCH
mem_read_byte  in  8  read data; valid the cycle after mem_read
pix_valid  out  1  pixel stream valid
pix_ready  in  1  display driver accepts pixel
pix_data  out  1  pixel value, 1 = lit
pix_x  out  7  output column (0..63; 0..127 with doubling)
pix_y  out  6  output row (0..31; 0..63 with doubling)
pix_last  out  1  high with the final pixel of the frame

Behaviour:
- Reset (async): state IDLE; busy, mem_read, pix_valid, pix_data, pix_last = 0; mem_addr, pix_x, pix_y = 0; internal counters and shift register cleared. Reset mid-frame abandons the frame; no further reads or pixels.
- States: IDLE, FETCH, WAIT, EMIT.
- IDLE: on start, load mem_addr = screen_start, zero row/byte/bit counters, busy=1, go FETCH. start while busy is ignored.
- FETCH: mem_read = mem_grant (combinational). Stay in FETCH until mem_grant=1; in that cycle go WAIT. mem_addr is held unchanged throughout FETCH.
- WAIT: capture mem_read_byte into an 8-bit shift register, bit counter = 0, go EMIT. pix_valid rises on that edge.
- EMIT: pix_data = shreg[7] (MSB = leftmost pixel). On pix_valid && pix_ready, shift left and advance x. pix_valid, pix_data, pix_x, pix_y must stay stable while pix_ready=0.
- After the 8th bit of a byte handshakes: if it was the last byte of the frame, pix_valid=0, busy=0, go IDLE. Otherwise mem_addr <= mem_addr+1 (row wrap is implicit: addr = screen_start + row*bytes_per_row + byte), go FETCH; pix_valid=0 during the FETCH/WAIT gap.
- Latency with mem_grant held high: mem_read in the first cycle after start is sampled; pix_valid asserted 2 cycles later. Per byte: 8 handshake cycles + 2 refill cycles.
- pix_last = pix_valid && final pixel of frame; busy falls on the same edge its handshake completes.
- Frame order: row 0..rows-1, within a row x 0..63. Each frame issues exactly rows*bytes_per_row reads (256 by default).
- mem_addr arithmetic: 16-bit, no wrap within the default range. No writes are ever issued (no mem_write port).

Optional Feature:
SCREEN_SCAN_DOUBLE_EN. Defined: 2x pixel doubling for a 128 x 64 panel. Each bit is emitted twice (pix_x 0..127). Each framebuffer row is emitted twice by re-fetching its 8 bytes (pix_y 0..63), giving 512 reads and 8192 pixels per frame. pix_last is on pixel (127,63). Undefined: 1x output, 256 reads, 2048 pixels; pix_x and pix_y upper bits are always 0.

Decomposition:
- Shared package: state encodings (IDLE/FETCH/WAIT/EMIT), default screen_start 'h100, screen width 64 / height 32 constants, shared with the GPU.
- One natural sub-module, scan_shifter: an 8-bit load/shift register with bit counter, the doubling repeat counter and the valid/ready hold logic.
- Address/row sequencing stays in screen_scan.

Test Plan:
- Framebuffer byte 'h100 = 'hA5, rest 0, grant and ready high, start pulse -> first 8 pixels 1,0,1,0,0,1,0,1 at x 0..7 y 0; 2048 pixels total; pix_last only at (63,31); busy low after.
- Byte 'h1FF = 'h01 -> only pixel (63,31) lit; exactly 256 reads, addresses 'h100..'h1FF ascending.
- mem_grant low for 5 cycles during the FETCH of 'h108 -> mem_read stays 0, mem_addr holds 'h108; stream resumes with correct row 1 data.
- pix_ready toggled randomly -> pixel sequence identical to the all-ready run; outputs stable while stalled.
- Reset asserted after 100 pixels, then released and start pulsed -> all outputs 0 during reset; new frame begins at (0,0) with read of 'h100.
- SCREEN_SCAN_DOUBLE_EN defined with 'h100 = 'h80 -> pixels (0,0),(1,0),(0,1),(1,1) lit; 512 reads; 8192 pixels.
